tag_array_nway: RTL and testbench

Set-associative tag store with per-way valid bits, a parallel tag compare, and a hardware flush walker, for the L1 cache. It generalises the single-tag-per-set array: it holds NUM_WAYS tags per set and returns a registered hit/way result one cycle after a lookup. It sits between the L1 controller's lookup stage and its refill/replacement logic.

---
 rtl/tag_array_nway.sv | 149 ++++++++++++++
 tb/tb_tag_array_nway.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_array_nway.sv
// Set-associative tag store: NUM_WAYS tags per set with per-way valid bits,
// a registered parallel tag compare, and a flush walker that invalidates
// one set per cycle.
module tag_array_nway #(
  parameter int unsigned NUM_SETS   = 64,
  parameter int unsigned NUM_WAYS   = 4,
  parameter int unsigned TAG_BITS   = 22,
  parameter int unsigned INDEX_BITS = $clog2(NUM_SETS),
  parameter int unsigned WAY_BITS   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         lookup_valid,
  output logic                         lookup_ready,
  input  logic [INDEX_BITS-1:0]        lookup_index,
  input  logic [TAG_BITS-1:0]          lookup_tag,
  output logic                         hit_valid,
  output logic                         hit,
  output logic [WAY_BITS-1:0]          hit_way,
  output logic                         multi_hit,
  output logic [NUM_WAYS*TAG_BITS-1:0] rd_tags,
  output logic [NUM_WAYS-1:0]          rd_valid,
  input  logic                         we,
  input  logic [INDEX_BITS-1:0]        wr_index,
  input  logic [WAY_BITS-1:0]          wr_way,
  input  logic [TAG_BITS-1:0]          wr_tag,
  input  logic                         wr_valid,
  input  logic                         flush_req,
  output logic                         flush_busy,
  output logic                         flush_done
);

  typedef enum logic [1:0] {IDLE, FLUSH, DONE} state_t;

  state_t                      state, state_next;
  logic [INDEX_BITS-1:0]       cnt;
  logic [NUM_WAYS*TAG_BITS-1:0] tag_mem   [NUM_SETS];
  logic [NUM_WAYS-1:0]         valid_mem [NUM_SETS];

  logic                        accept;
  logic                        wr_en;
  logic [NUM_WAYS-1:0]         wr_mask;
  logic [NUM_WAYS*TAG_BITS-1:0] sel_tags;
  logic [NUM_WAYS-1:0]         sel_valid;
  logic [NUM_WAYS-1:0]         match;
  logic                        any_match;
  logic                        many_match;
  logic [WAY_BITS-1:0]         first_way;

  assign flush_busy   = (state == FLUSH);
  assign flush_done   = (state == DONE);
  assign lookup_ready = !flush_busy;
  assign accept       = lookup_valid && lookup_ready;
  assign wr_en        = we && !flush_busy;

  // One-hot way select for writes; a single-way array ignores wr_way.
  always_comb begin
    wr_mask = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if ((NUM_WAYS == 1) || (WAY_BITS'(w) == wr_way)) wr_mask[w] = 1'b1;
    end
  end

  // Parallel compare against the pre-write contents of the looked-up set.
  always_comb begin
    sel_tags   = tag_mem[lookup_index];
    sel_valid  = valid_mem[lookup_index];
    match      = '0;
    any_match  = 1'b0;
    many_match = 1'b0;
    first_way  = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      match[w] = sel_valid[w] && (sel_tags[w*TAG_BITS +: TAG_BITS] == lookup_tag);
      if (match[w]) begin
        if (any_match) begin
          many_match = 1'b1;
        end else begin
          any_match = 1'b1;
          first_way = WAY_BITS'(w);
        end
      end
    end
  end

  // Flush walker next-state logic; requests outside IDLE are ignored.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (flush_req) state_next = FLUSH;
      FLUSH:   if (cnt == INDEX_BITS'(NUM_SETS - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register and set counter for the walker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state == FLUSH) cnt <= cnt + 1'b1;
      else                cnt <= '0;
    end
  end

  // Tag RAM: no reset, written only when a write is accepted.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned w = 0; w < NUM_WAYS; w++) begin
        if (wr_mask[w]) tag_mem[wr_index][w*TAG_BITS +: TAG_BITS] <= wr_tag;
      end
    end
  end

  // Valid bits: cleared by reset and by the walker, else updated by writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < NUM_SETS; s++) valid_mem[s] <= '0;
    end else if (state == FLUSH) begin
      valid_mem[cnt] <= '0;
    end else if (wr_en) begin
      valid_mem[wr_index] <= (valid_mem[wr_index] & ~wr_mask) | (wr_valid ? wr_mask : '0);
    end
  end

  // Registered lookup results; hit_valid strobes, the rest hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_valid <= 1'b0;
      hit       <= 1'b0;
      hit_way   <= '0;
      multi_hit <= 1'b0;
      rd_tags   <= '0;
      rd_valid  <= '0;
    end else begin
      hit_valid <= accept;
      if (accept) begin
        hit       <= any_match;
        hit_way   <= first_way;
        multi_hit <= many_match;
        rd_tags   <= sel_tags;
        rd_valid  <= sel_valid;
      end
    end
  end

endmodule

// File: tb/tb_tag_array_nway.sv
// Bench for tag_array_nway: directed steps on the default 64x4 array, then a
// random phase on 1-way and 8-way arrays against an array-based model.
module tb_tag_array_nway;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Default configuration
  logic        d_lookup_valid, d_lookup_ready;
  logic [5:0]  d_lookup_index;
  logic [21:0] d_lookup_tag;
  logic        d_hit_valid, d_hit, d_multi_hit;
  logic [1:0]  d_hit_way;
  logic [87:0] d_rd_tags;
  logic [3:0]  d_rd_valid;
  logic        d_we, d_wr_valid, d_flush_req, d_flush_busy, d_flush_done;
  logic [5:0]  d_wr_index;
  logic [1:0]  d_wr_way;
  logic [21:0] d_wr_tag;

  // Shared random-phase inputs
  logic        r_lookup_valid;
  logic [2:0]  r_lookup_index;
  logic [21:0] r_lookup_tag;
  logic        r_we, r_wr_valid;
  logic [2:0]  r_wr_index;
  logic [21:0] r_wr_tag;
  logic        r_wr_way1;
  logic [2:0]  r_wr_way8;
  logic        r_flush_req;

  logic         o1_ready, o1_hit_valid, o1_hit, o1_multi, o1_busy, o1_done;
  logic         o1_hit_way;
  logic [21:0]  o1_rd_tags;
  logic         o1_rd_valid;
  logic         o8_ready, o8_hit_valid, o8_hit, o8_multi, o8_busy, o8_done;
  logic [2:0]   o8_hit_way;
  logic [175:0] o8_rd_tags;
  logic [7:0]   o8_rd_valid;

  tag_array_nway #(.NUM_SETS(64), .NUM_WAYS(4), .TAG_BITS(22)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .lookup_valid(d_lookup_valid), .lookup_ready(d_lookup_ready),
    .lookup_index(d_lookup_index), .lookup_tag(d_lookup_tag),
    .hit_valid(d_hit_valid), .hit(d_hit), .hit_way(d_hit_way), .multi_hit(d_multi_hit),
    .rd_tags(d_rd_tags), .rd_valid(d_rd_valid),
    .we(d_we), .wr_index(d_wr_index), .wr_way(d_wr_way), .wr_tag(d_wr_tag), .wr_valid(d_wr_valid),
    .flush_req(d_flush_req), .flush_busy(d_flush_busy), .flush_done(d_flush_done)
  );

  tag_array_nway #(.NUM_SETS(8), .NUM_WAYS(1), .TAG_BITS(22)) u_w1 (
    .clk(clk), .rst_n(rst_n),
    .lookup_valid(r_lookup_valid), .lookup_ready(o1_ready),
    .lookup_index(r_lookup_index), .lookup_tag(r_lookup_tag),
    .hit_valid(o1_hit_valid), .hit(o1_hit), .hit_way(o1_hit_way), .multi_hit(o1_multi),
    .rd_tags(o1_rd_tags), .rd_valid(o1_rd_valid),
    .we(r_we), .wr_index(r_wr_index), .wr_way(r_wr_way1), .wr_tag(r_wr_tag), .wr_valid(r_wr_valid),
    .flush_req(r_flush_req), .flush_busy(o1_busy), .flush_done(o1_done)
  );

  tag_array_nway #(.NUM_SETS(8), .NUM_WAYS(8), .TAG_BITS(22)) u_w8 (
    .clk(clk), .rst_n(rst_n),
    .lookup_valid(r_lookup_valid), .lookup_ready(o8_ready),
    .lookup_index(r_lookup_index), .lookup_tag(r_lookup_tag),
    .hit_valid(o8_hit_valid), .hit(o8_hit), .hit_way(o8_hit_way), .multi_hit(o8_multi),
    .rd_tags(o8_rd_tags), .rd_valid(o8_rd_valid),
    .we(r_we), .wr_index(r_wr_index), .wr_way(r_wr_way8), .wr_tag(r_wr_tag), .wr_valid(r_wr_valid),
    .flush_req(r_flush_req), .flush_busy(o8_busy), .flush_done(o8_done)
  );

  // Reference model for the random phase: per-set, per-way contents.
  logic [21:0] m_tag1 [8];
  bit          m_val1 [8];
  bit          m_wr1  [8];
  logic [21:0] m_tag8 [8][8];
  bit          m_val8 [8][8];
  bit          m_wr8  [8][8];

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    d_we = 1'b0;
    d_lookup_valid = 1'b0;
    d_flush_req = 1'b0;
  endtask

  task automatic dwrite(input int s, input int w, input logic [21:0] t, input logic v);
    d_we = 1'b1;
    d_wr_index = 6'(s);
    d_wr_way = 2'(w);
    d_wr_tag = t;
    d_wr_valid = v;
  endtask

  task automatic dlook(input int s, input logic [21:0] t);
    d_lookup_valid = 1'b1;
    d_lookup_index = 6'(s);
    d_lookup_tag = t;
  endtask

  initial begin
    int busy_cycles;
    logic        e1_hit, e8_hit, e8_multi;
    logic [2:0]  e8_way;
    logic [7:0]  e8_rdv;
    logic        e1_rdv;
    logic        la;
    int          nm;
    int          ls;
    logic [21:0] lt;

    idle();
    d_lookup_index = '0; d_lookup_tag = '0;
    d_wr_index = '0; d_wr_way = '0; d_wr_tag = '0; d_wr_valid = 1'b0;
    r_lookup_valid = 1'b0; r_lookup_index = '0; r_lookup_tag = '0;
    r_we = 1'b0; r_wr_valid = 1'b0; r_wr_index = '0; r_wr_tag = '0;
    r_wr_way1 = 1'b0; r_wr_way8 = '0; r_flush_req = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;

    // Reset values
    chk("rst_hit_valid", 64'(d_hit_valid), 0);
    chk("rst_hit", 64'(d_hit), 0);
    chk("rst_hit_way", 64'(d_hit_way), 0);
    chk("rst_multi", 64'(d_multi_hit), 0);
    chk("rst_rd_valid", 64'(d_rd_valid), 0);
    chk("rst_rd_tags_zero", 64'(d_rd_tags == '0), 1);
    chk("rst_busy", 64'(d_flush_busy), 0);
    chk("rst_done", 64'(d_flush_done), 0);
    chk("rst_ready", 64'(d_lookup_ready), 1);
    cyc(); cyc();
    chk("rst_ready_held", 64'(d_lookup_ready), 1);
    rst_n = 1'b1;
    cyc();

    // Write then lookup
    dwrite(5, 2, 22'h12345, 1'b1);
    cyc();
    idle(); dlook(5, 22'h12345);
    cyc();
    chk("wl_hit_valid", 64'(d_hit_valid), 1);
    chk("wl_hit", 64'(d_hit), 1);
    chk("wl_hit_way", 64'(d_hit_way), 2);
    chk("wl_multi", 64'(d_multi_hit), 0);
    chk("wl_rd_valid", 64'(d_rd_valid), 64'h4);
    chk("wl_rd_tag2", 64'(d_rd_tags[2*22 +: 22]), 64'h12345);
    idle();
    cyc();
    chk("hold_hit_valid", 64'(d_hit_valid), 0);
    chk("hold_hit", 64'(d_hit), 1);
    chk("hold_hit_way", 64'(d_hit_way), 2);

    // Same-cycle write and lookup sees the old contents
    dwrite(9, 0, 22'hABC, 1'b1); dlook(9, 22'hABC);
    cyc();
    chk("coll_hit_valid", 64'(d_hit_valid), 1);
    chk("coll_hit", 64'(d_hit), 0);
    chk("coll_hit_way", 64'(d_hit_way), 0);
    d_we = 1'b0;
    cyc();
    chk("coll_next_hit", 64'(d_hit), 1);
    chk("coll_next_way", 64'(d_hit_way), 0);

    // Multi-hit, then invalidate the lower way
    idle(); dwrite(0, 1, 22'h7, 1'b1);
    cyc();
    dwrite(0, 3, 22'h7, 1'b1);
    cyc();
    d_we = 1'b0; dlook(0, 22'h7);
    cyc();
    chk("mh_hit", 64'(d_hit), 1);
    chk("mh_way", 64'(d_hit_way), 1);
    chk("mh_multi", 64'(d_multi_hit), 1);
    chk("mh_rd_valid", 64'(d_rd_valid), 64'hA);
    d_lookup_valid = 1'b0; dwrite(0, 1, 22'h7, 1'b0);
    cyc();
    d_we = 1'b0; dlook(0, 22'h7);
    cyc();
    chk("inv_hit", 64'(d_hit), 1);
    chk("inv_way", 64'(d_hit_way), 3);
    chk("inv_multi", 64'(d_multi_hit), 0);
    chk("inv_rd_valid", 64'(d_rd_valid), 64'h8);

    // Fill sets 0 and 63, then flush
    idle();
    for (int w = 0; w < 4; w++) begin
      dwrite(0, w, 22'(32'h100 + w), 1'b1); cyc();
      dwrite(63, w, 22'(32'h200 + w), 1'b1); cyc();
    end
    idle();
    d_flush_req = 1'b1; dlook(63, 22'h202);
    cyc();
    d_flush_req = 1'b0; dlook(0, 22'h100);
    busy_cycles = 0;
    for (int i = 1; i <= 64; i++) begin
      chk("fl_busy", 64'(d_flush_busy), 1);
      chk("fl_ready", 64'(d_lookup_ready), 0);
      chk("fl_done", 64'(d_flush_done), 0);
      chk("fl_hit_valid", 64'(d_hit_valid), (i == 1) ? 1 : 0);
      if (i == 1) begin
        chk("fl_pre_hit", 64'(d_hit), 1);
        chk("fl_pre_way", 64'(d_hit_way), 2);
      end
      if (d_flush_busy) busy_cycles++;
      dwrite(10, i % 4, 22'h55, 1'b1);
      d_flush_req = (i == 10);
      cyc();
    end
    d_we = 1'b0; d_flush_req = 1'b0;
    chk("fl_end_busy", 64'(d_flush_busy), 0);
    chk("fl_end_done", 64'(d_flush_done), 1);
    chk("fl_end_ready", 64'(d_lookup_ready), 1);
    chk("fl_end_hit_valid", 64'(d_hit_valid), 0);
    chk("fl_busy_cycles", 64'(busy_cycles), 64);
    cyc();
    chk("fl_after_done", 64'(d_flush_done), 0);
    chk("fl_after_busy", 64'(d_flush_busy), 0);
    chk("fl_s0_hit_valid", 64'(d_hit_valid), 1);
    chk("fl_s0_hit", 64'(d_hit), 0);
    chk("fl_s0_rd_valid", 64'(d_rd_valid), 0);
    dlook(63, 22'h202);
    cyc();
    chk("fl_s63_hit", 64'(d_hit), 0);
    chk("fl_s63_rd_valid", 64'(d_rd_valid), 0);
    dlook(10, 22'h55);
    cyc();
    chk("fl_drop_hit", 64'(d_hit), 0);
    chk("fl_drop_rd_valid", 64'(d_rd_valid), 0);

    // Reset in the middle of a flush
    idle(); dwrite(3, 0, 22'h33, 1'b1);
    cyc();
    dwrite(40, 1, 22'h44, 1'b1);
    cyc();
    idle(); dlook(40, 22'h44); d_flush_req = 1'b1;
    cyc();
    idle();
    chk("mr_pre_hit", 64'(d_hit), 1);
    repeat (20) cyc();
    chk("mr_busy_before", 64'(d_flush_busy), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_busy", 64'(d_flush_busy), 0);
    chk("mr_done", 64'(d_flush_done), 0);
    chk("mr_ready", 64'(d_lookup_ready), 1);
    chk("mr_hit", 64'(d_hit), 0);
    chk("mr_hit_way", 64'(d_hit_way), 0);
    chk("mr_rd_valid", 64'(d_rd_valid), 0);
    chk("mr_rd_tags_zero", 64'(d_rd_tags == '0), 1);
    cyc();
    rst_n = 1'b1;
    dlook(40, 22'h44);
    cyc();
    chk("mr_post_hit_valid", 64'(d_hit_valid), 1);
    chk("mr_post_hit", 64'(d_hit), 0);
    chk("mr_post_rd_valid", 64'(d_rd_valid), 0);
    idle();

    // Random phase on the 1-way and 8-way arrays
    for (int s = 0; s < 8; s++) begin
      m_val1[s] = 1'b0; m_wr1[s] = 1'b0; m_tag1[s] = '0;
      for (int w = 0; w < 8; w++) begin
        m_val8[s][w] = 1'b0; m_wr8[s][w] = 1'b0; m_tag8[s][w] = '0;
      end
    end
    e1_hit = 1'b0; e1_rdv = 1'b0;
    e8_hit = 1'b0; e8_way = '0; e8_multi = 1'b0; e8_rdv = '0;
    for (int n = 0; n < 10000; n++) begin
      r_we           = 1'($urandom_range(0, 1));
      r_wr_index     = 3'($urandom_range(0, 7));
      r_wr_tag       = 22'($urandom_range(0, 3));
      r_wr_valid     = ($urandom_range(0, 3) != 0);
      r_wr_way8      = 3'($urandom_range(0, 7));
      r_lookup_valid = ($urandom_range(0, 3) != 0);
      r_lookup_index = 3'($urandom_range(0, 7));
      r_lookup_tag   = 22'($urandom_range(0, 3));
      la = r_lookup_valid;
      ls = int'(r_lookup_index);
      lt = r_lookup_tag;
      if (la) begin
        e1_hit = m_val1[ls] && (m_tag1[ls] == lt);
        e1_rdv = m_val1[ls];
        nm = 0; e8_way = '0;
        for (int w = 0; w < 8; w++) begin
          e8_rdv[w] = m_val8[ls][w];
          if (m_val8[ls][w] && (m_tag8[ls][w] == lt)) begin
            if (nm == 0) e8_way = 3'(w);
            nm++;
          end
        end
        e8_hit = (nm > 0);
        e8_multi = (nm > 1);
      end
      cyc();
      chk("r1_hit_valid", 64'(o1_hit_valid), 64'(la));
      chk("r1_hit", 64'(o1_hit), 64'(e1_hit));
      chk("r1_hit_way", 64'(o1_hit_way), 0);
      chk("r1_multi", 64'(o1_multi), 0);
      chk("r1_rd_valid", 64'(o1_rd_valid), 64'(e1_rdv));
      chk("r8_hit_valid", 64'(o8_hit_valid), 64'(la));
      chk("r8_hit", 64'(o8_hit), 64'(e8_hit));
      chk("r8_hit_way", 64'(o8_hit_way), 64'(e8_way));
      chk("r8_multi", 64'(o8_multi), 64'(e8_multi));
      chk("r8_rd_valid", 64'(o8_rd_valid), 64'(e8_rdv));
      if (la) begin
        if (m_wr1[ls]) chk("r1_rd_tag", 64'(o1_rd_tags), 64'(m_tag1[ls]));
        for (int w = 0; w < 8; w++) begin
          if (m_wr8[ls][w]) chk("r8_rd_tag", 64'(o8_rd_tags[w*22 +: 22]), 64'(m_tag8[ls][w]));
        end
      end
      if (r_we) begin
        m_tag1[r_wr_index] = r_wr_tag;
        m_val1[r_wr_index] = r_wr_valid;
        m_wr1[r_wr_index]  = 1'b1;
        m_tag8[r_wr_index][r_wr_way8] = r_wr_tag;
        m_val8[r_wr_index][r_wr_way8] = r_wr_valid;
        m_wr8[r_wr_index][r_wr_way8]  = 1'b1;
      end
    end
    r_we = 1'b0; r_lookup_valid = 1'b0;
    chk("r1_never_busy", 64'(o1_busy), 0);
    chk("r8_never_busy", 64'(o8_busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
